// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and types for the multi-channel clock divider.
package clk_div_pkg;
   localparam int CNT_W_DEF = 32;
   localparam int MAX_CH = 8;
   typedef logic [CNT_W_DEF-1:0] div_t;
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel; a new half-period is latched as pending and
// only loaded at a terminal count so no half-period is ever truncated.
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int          CNT_W       = CNT_W_DEF,
   parameter int unsigned DIV_DEFAULT = 25_000_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             hold,
   input  logic             wr,
   input  logic [CNT_W-1:0] val,
   output logic             pend,
   output logic             clk_slow,
   output logic             tick
);
   logic [CNT_W-1:0] cnt, half, pend_div, eff;
   logic             term;
   always_comb begin
      eff  = (half == '0) ? CNT_W'(1) : half;
      term = en && (cnt == eff - CNT_W'(1));
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt      <= '0;
         half     <= CNT_W'(DIV_DEFAULT);
         pend_div <= '0;
         pend     <= 1'b0;
         clk_slow <= 1'b0;
         tick     <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (hold) begin
            cnt      <= '0;
            clk_slow <= 1'b0;
         end else if (term) begin
            cnt      <= '0;
            clk_slow <= !clk_slow;
            tick     <= !clk_slow;
            if (pend) begin
               half <= pend_div;
               pend <= 1'b0;
            end
         end else if (en) begin
            cnt <= cnt + CNT_W'(1);
         end
         // a write landing on a terminal count re-arms pend for the next boundary
         if (wr) begin
            pend_div <= val;
            pend     <= 1'b1;
         end
      end
   end
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH runtime-programmable clock dividers with glitch-free divisor update.
// Define CLK_DIV_STEP_EN to add single-step control of channel 0 (step_mode, step_req).
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter int          NUM_CH      = 2,
   parameter int          CNT_W       = CNT_W_DEF,
   parameter int unsigned DIV_DEFAULT = 25_000_000,
   localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] en,
   input  logic              div_wr,
   input  logic [CH_W-1:0]   div_ch,
   input  logic [CNT_W-1:0]  div_val,
`ifdef CLK_DIV_STEP_EN
   input  logic              step_mode,
   input  logic              step_req,
`endif
   output logic [NUM_CH-1:0] div_pend,
   output logic [NUM_CH-1:0] clk_slow,
   output logic [NUM_CH-1:0] tick
);
   logic [NUM_CH-1:0] slow_c, tick_c;
   logic              step_hold;
`ifdef CLK_DIV_STEP_EN
   logic req_q, req_qq, step_pulse;
   assign step_hold = step_mode;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         req_q      <= 1'b0;
         req_qq     <= 1'b0;
         step_pulse <= 1'b0;
      end else begin
         req_q      <= step_req;
         req_qq     <= req_q;
         step_pulse <= step_mode && req_q && !req_qq;
      end
   end
   always_comb begin
      clk_slow = slow_c;
      tick     = tick_c;
      if (step_mode) begin
         clk_slow[0] = step_pulse;
         tick[0]     = step_pulse;
      end
   end
`else
   assign step_hold = 1'b0;
   assign clk_slow  = slow_c;
   assign tick      = tick_c;
`endif
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clk_div_chan #(.CNT_W(CNT_W), .DIV_DEFAULT(DIV_DEFAULT)) u_chan (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (en[i]),
         .hold     (i == 0 && step_hold),
         .wr       (div_wr && div_ch == CH_W'(i)),
         .val      (div_val),
         .pend     (div_pend[i]),
         .clk_slow (slow_c[i]),
         .tick     (tick_c[i])
      );
   end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed and random checks of clk_div_multi against a count-down reference model.
module tb_clk_div_multi;
   localparam int NCH = 3, CW = 16, DIV = 3;
   logic clk = 0, rst_n = 0, div_wr = 0, step_mode = 0, step_req = 0;
   logic [NCH-1:0] en = '0;
   logic [1:0] div_ch = '0;
   logic [CW-1:0] div_val = '0;
   logic [NCH-1:0] div_pend, clk_slow, tick;
   int asserts = 0, fails = 0;
   int m_half[NCH], m_rem[NCH], m_pval[NCH];
   bit m_pend[NCH], m_lvl[NCH], m_tick[NCH];
   bit m_r1, m_r2, m_sp;

   always #5 clk = ~clk;

   clk_div_multi #(.NUM_CH(NCH), .CNT_W(CW), .DIV_DEFAULT(DIV)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .div_wr(div_wr), .div_ch(div_ch), .div_val(div_val),
`ifdef CLK_DIV_STEP_EN
      .step_mode(step_mode), .step_req(step_req),
`endif
      .div_pend(div_pend), .clk_slow(clk_slow), .tick(tick)
   );

   function automatic int eff(int h);
      return (h == 0) ? 1 : h;
   endfunction

   // model: m_rem = enabled cycles left in the current half-period
   always @(posedge clk) begin
      m_sp = rst_n && step_mode && m_r1 && !m_r2;
      m_r2 = rst_n && m_r1;
      m_r1 = rst_n && step_req;
      for (int c = 0; c < NCH; c++) begin
         m_tick[c] = 0;
         if (!rst_n) begin
            m_half[c] = DIV; m_rem[c] = eff(DIV); m_pend[c] = 0; m_lvl[c] = 0;
         end else begin
            if (c == 0 && step_mode) begin
               m_rem[c] = eff(m_half[c]); m_lvl[c] = 0;
            end else if (en[c]) begin
               m_rem[c]--;
               if (m_rem[c] == 0) begin
                  m_lvl[c] = !m_lvl[c];
                  m_tick[c] = m_lvl[c];
                  if (m_pend[c]) begin m_half[c] = m_pval[c]; m_pend[c] = 0; end
                  m_rem[c] = eff(m_half[c]);
               end
            end
            if (div_wr && div_ch == c) begin m_pval[c] = div_val; m_pend[c] = 1; end
         end
      end
   end

   function automatic logic [3*NCH-1:0] exp_all();
      logic [NCH-1:0] p, s, t;
      for (int c = 0; c < NCH; c++) begin p[c] = m_pend[c]; s[c] = m_lvl[c]; t[c] = m_tick[c]; end
      if (step_mode) begin s[0] = m_sp; t[0] = m_sp; end
      return {p, s, t};
   endfunction

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      int nt, nh;
      nt = 0; nh = 0;
      rst_n = 0; en = '1;
      cyc(); cyc();
      asserts++; if ({div_pend, clk_slow, tick} !== '0) begin fails++; $display("FAIL reset_state: got %b want 0", {div_pend, clk_slow, tick}); end
      rst_n = 1;
      repeat (18) begin
         cyc();
         asserts++; if ({div_pend, clk_slow, tick} !== exp_all()) begin fails++; $display("FAIL reset_run: got %b want %b", {div_pend, clk_slow, tick}, exp_all()); end
         nt += tick[1]; nh += clk_slow[1];
      end
      asserts++; if (nt !== 3) begin fails++; $display("FAIL reset_ticks: got %0d want 3", nt); end
      asserts++; if (nh !== 9) begin fails++; $display("FAIL reset_duty: got %0d want 9", nh); end
   endtask

   task automatic test_half_zero();
      int nt;
      nt = 0;
      div_wr = 1; div_ch = 0; div_val = 0; cyc();
      div_ch = 2; cyc();
      div_wr = 0;
      for (int k = 0; k < 20; k++) begin
         cyc();
         asserts++; if ({div_pend, clk_slow, tick} !== exp_all()) begin fails++; $display("FAIL half0_run: got %b want %b", {div_pend, clk_slow, tick}, exp_all()); end
         if (k >= 10) nt += tick[0];
      end
      asserts++; if (nt !== 5) begin fails++; $display("FAIL half0_ticks: got %0d want 5", nt); end
   endtask

   task automatic test_pending();
      int k, n;
      logic lv;
      div_wr = 1; div_ch = 1; div_val = 4; cyc();
      div_wr = 0;
      k = 0; while (div_pend[1] && k < 20) begin cyc(); k++; end
      asserts++; if (div_pend[1] !== 1'b0) begin fails++; $display("FAIL pend_apply4: got %b want 0", div_pend[1]); end
      k = 0; while (eff(m_half[1]) - m_rem[1] != 1 && k < 20) begin cyc(); k++; end
      lv = clk_slow[1];
      div_wr = 1; div_ch = 1; div_val = 2; cyc();
      div_wr = 0;
      asserts++; if (div_pend[1] !== 1'b1) begin fails++; $display("FAIL pend_set: got %b want 1", div_pend[1]); end
      n = 1; while (clk_slow[1] === lv && n < 12) begin cyc(); n++; end
      asserts++; if (n !== 3) begin fails++; $display("FAIL pend_old_half: got %0d want 3", n); end
      asserts++; if (div_pend[1] !== 1'b0) begin fails++; $display("FAIL pend_clear: got %b want 0", div_pend[1]); end
      lv = clk_slow[1]; n = 0;
      do begin cyc(); n++; end while (clk_slow[1] === lv && n < 12);
      asserts++; if (n !== 2) begin fails++; $display("FAIL pend_new_half: got %0d want 2", n); end
   endtask

   task automatic test_overwrite();
      int k, n;
      logic lv;
      div_wr = 1; div_ch = 2; div_val = 3; cyc();
      div_wr = 0;
      k = 0; while (div_pend[2] && k < 20) begin cyc(); k++; end
      k = 0; while (m_rem[2] != 1 && k < 20) begin cyc(); k++; end
      div_wr = 1; div_ch = 2; div_val = 7; cyc();
      lv = clk_slow[2];
      div_val = 5; cyc();
      div_wr = 0;
      asserts++; if (div_pend[2] !== 1'b1) begin fails++; $display("FAIL ovw_pend: got %b want 1", div_pend[2]); end
      n = 1; while (clk_slow[2] === lv && n < 12) begin cyc(); n++; end
      asserts++; if (n !== 3) begin fails++; $display("FAIL ovw_cur_half: got %0d want 3", n); end
      lv = clk_slow[2]; n = 0;
      do begin cyc(); n++; end while (clk_slow[2] === lv && n < 12);
      asserts++; if (n !== 5) begin fails++; $display("FAIL ovw_last_value: got %0d want 5", n); end
      div_wr = 1; div_ch = 3; div_val = 1; cyc();
      div_wr = 0;
      asserts++; if (div_pend !== '0) begin fails++; $display("FAIL bad_ch_ignored: got %b want 000", div_pend); end
      repeat (12) begin
         cyc();
         asserts++; if ({div_pend, clk_slow, tick} !== exp_all()) begin fails++; $display("FAIL bad_ch_run: got %b want %b", {div_pend, clk_slow, tick}, exp_all()); end
      end
   endtask

   task automatic test_pause();
      logic s;
      cyc();
      en[1] = 0; s = clk_slow[1];
      repeat (7) begin
         cyc();
         asserts++; if ({clk_slow[1], tick[1]} !== {s, 1'b0}) begin fails++; $display("FAIL pause_hold: got %b want %b", {clk_slow[1], tick[1]}, {s, 1'b0}); end
         asserts++; if ({div_pend, clk_slow, tick} !== exp_all()) begin fails++; $display("FAIL pause_run: got %b want %b", {div_pend, clk_slow, tick}, exp_all()); end
      end
      en[1] = 1;
      repeat (15) begin
         cyc();
         asserts++; if ({div_pend, clk_slow, tick} !== exp_all()) begin fails++; $display("FAIL pause_resume: got %b want %b", {div_pend, clk_slow, tick}, exp_all()); end
      end
   endtask

`ifdef CLK_DIV_STEP_EN
   task automatic test_step();
      int np, pos;
      np = 0;
      en = '1; step_mode = 1;
      cyc(); cyc();
      for (int p = 0; p < 3; p++) begin
         pos = 0; step_req = 1;
         for (int k = 1; k <= 5; k++) begin
            cyc(); step_req = 0;
            asserts++; if ({div_pend, clk_slow, tick} !== exp_all()) begin fails++; $display("FAIL step_run: got %b want %b", {div_pend, clk_slow, tick}, exp_all()); end
            if (clk_slow[0]) begin np++; pos = k; end
         end
         asserts++; if (pos !== 2) begin fails++; $display("FAIL step_latency: got %0d want 2", pos); end
      end
      asserts++; if (np !== 3) begin fails++; $display("FAIL step_count: got %0d want 3", np); end
      step_mode = 0;
      repeat (10) begin
         cyc();
         asserts++; if ({div_pend, clk_slow, tick} !== exp_all()) begin fails++; $display("FAIL step_exit: got %b want %b", {div_pend, clk_slow, tick}, exp_all()); end
      end
   endtask
`endif

   task automatic test_random();
      repeat (400) begin
         en = NCH'($urandom);
         div_wr = ($urandom_range(0, 3) == 0);
         div_ch = 2'($urandom_range(0, 3));
         div_val = CW'($urandom_range(0, 5));
         cyc();
         asserts++; if ({div_pend, clk_slow, tick} !== exp_all()) begin fails++; $display("FAIL random: got %b want %b", {div_pend, clk_slow, tick}, exp_all()); end
      end
      div_wr = 0;
   endtask

   task automatic test_reset_mid();
      int nt;
      nt = 0;
      en = '1;
      div_wr = 1; div_ch = 1; div_val = 9; cyc();
      div_wr = 0;
      cyc(); cyc();
      rst_n = 0; cyc();
      asserts++; if ({div_pend, clk_slow, tick} !== '0) begin fails++; $display("FAIL reset_mid: got %b want 0", {div_pend, clk_slow, tick}); end
      rst_n = 1;
      repeat (18) begin
         cyc();
         asserts++; if ({div_pend, clk_slow, tick} !== exp_all()) begin fails++; $display("FAIL reset_mid_run: got %b want %b", {div_pend, clk_slow, tick}, exp_all()); end
         nt += tick[1];
      end
      asserts++; if (nt !== 3) begin fails++; $display("FAIL reset_mid_default: got %0d want 3", nt); end
   endtask

   initial begin
      test_reset();
      test_half_zero();
      test_pending();
      test_overwrite();
      test_pause();
`ifdef CLK_DIV_STEP_EN
      test_step();
`endif
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end
endmodule
